// File: rtl/flight_pkg.sv
`default_nettype none
// ============================================================================
// flight_pkg : shared constants, FSM state type and button indices
// Rev 1.0
// ============================================================================
package flight_pkg;

  localparam int INPUT_WIDTH  = 8;
  localparam int THROTTLE_MAX = 100;

  localparam int PITCH_UP   = 0;
  localparam int PITCH_DOWN = 1;
  localparam int ROLL_LEFT  = 2;
  localparam int ROLL_RIGHT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    READY = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/flight_input_responder_debouncer.sv
`default_nettype none
// ============================================================================
// debouncer : 2-flop synchronizer plus stable-count debouncer with rise pulse
// Rev 1.0
// ============================================================================
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule
`default_nettype wire

// File: rtl/flight_input_responder.sv
`default_nettype none
// ============================================================================
// flight_input_responder : pilot input conditioning and request/ready responder
// Rev 1.0 -- optional auto-repeat via FLIGHT_INPUT_THROTTLE_REPEAT_EN
// ============================================================================
module flight_input_responder #(
  parameter int INPUT_WIDTH     = flight_pkg::INPUT_WIDTH,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RATE_STEP       = 10,
  parameter int THROTTLE_STEP   = 5,
  parameter int THROTTLE_INIT   = 50,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          request_input,
  output logic                          input_ready,
  input  logic [3:0]                    btn_raw,
  input  logic                          thr_up_raw,
  input  logic                          thr_down_raw,
  output logic signed [INPUT_WIDTH-1:0] pitch_change,
  output logic signed [INPUT_WIDTH-1:0] roll_change,
  output logic [INPUT_WIDTH:0]          throttle
);

  import flight_pkg::*;

  localparam int TW     = INPUT_WIDTH + 1;
  localparam int THR_UP = 4;
  localparam int THR_DN = 5;

  localparam logic [TW:0]   STEP_X   = (TW+1)'(THROTTLE_STEP);
  localparam logic [TW:0]   MAX_X    = (TW+1)'(THROTTLE_MAX);
  localparam logic [TW-1:0] THR_INIT = TW'(THROTTLE_INIT);
  localparam logic signed [INPUT_WIDTH-1:0] RATE_POS = INPUT_WIDTH'(RATE_STEP);
  localparam logic signed [INPUT_WIDTH-1:0] RATE_NEG = -RATE_POS;

  logic [5:0] raw_w;
  logic [5:0] lvl_w;
  logic [5:0] rise_w;

  assign raw_w = {thr_down_raw, thr_up_raw, btn_raw};

  for (genvar gi = 0; gi < 6; gi++) begin : g_deb
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (raw_w[gi]),
      .level_o(lvl_w[gi]),
      .rise_o (rise_w[gi])
    );
  end

  logic up_ev, dn_ev;

`ifdef FLIGHT_INPUT_THROTTLE_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_up_q, rep_up_d, rep_dn_q, rep_dn_d;
  logic             rep_up, rep_dn, both_held;
  logic             unused_bits;

  assign both_held   = lvl_w[THR_UP] & lvl_w[THR_DN];
  assign unused_bits = ^rise_w[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_up_q <= '0;
      rep_dn_q <= '0;
    end else begin
      rep_up_q <= rep_up_d;
      rep_dn_q <= rep_dn_d;
    end
  end

  // Counters start from zero on the press edge and wrap on each repeat step.
  always_comb begin
    rep_up_d = '0;
    rep_dn_d = '0;
    rep_up   = 1'b0;
    rep_dn   = 1'b0;
    if (lvl_w[THR_UP] && !both_held) begin
      if (rep_up_q == REP_LAST) rep_up = 1'b1;
      else                      rep_up_d = rep_up_q + 1'b1;
    end
    if (lvl_w[THR_DN] && !both_held) begin
      if (rep_dn_q == REP_LAST) rep_dn = 1'b1;
      else                      rep_dn_d = rep_dn_q + 1'b1;
    end
  end

  assign up_ev = rise_w[THR_UP] | rep_up;
  assign dn_ev = rise_w[THR_DN] | rep_dn;
`else
  logic        unused_bits;
  logic [31:0] unused_repeat;

  assign unused_bits   = ^{rise_w[3:0], lvl_w[THR_DN:THR_UP]};
  assign unused_repeat = REPEAT_CYCLES;
  assign up_ev         = rise_w[THR_UP];
  assign dn_ev         = rise_w[THR_DN];
`endif

  logic [TW-1:0] thr_q, thr_d;
  logic [TW:0]   thr_x;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) thr_q <= THR_INIT;
    else       thr_q <= thr_d;
  end

  // One extra bit catches both overflow past the maximum and borrow below zero.
  always_comb begin
    thr_x = {1'b0, thr_q};
    thr_d = thr_q;
    if (up_ev && !dn_ev) begin
      thr_x = {1'b0, thr_q} + STEP_X;
      thr_d = (thr_x > MAX_X) ? MAX_X[TW-1:0] : thr_x[TW-1:0];
    end else if (dn_ev && !up_ev) begin
      thr_x = {1'b0, thr_q} - STEP_X;
      thr_d = thr_x[TW] ? '0 : thr_x[TW-1:0];
    end
  end

  logic signed [INPUT_WIDTH-1:0] pitch_w, roll_w;

  always_comb begin
    pitch_w = '0;
    roll_w  = '0;
    if (lvl_w[PITCH_UP] && !lvl_w[PITCH_DOWN])      pitch_w = RATE_POS;
    else if (lvl_w[PITCH_DOWN] && !lvl_w[PITCH_UP]) pitch_w = RATE_NEG;
    if (lvl_w[ROLL_RIGHT] && !lvl_w[ROLL_LEFT])     roll_w  = RATE_POS;
    else if (lvl_w[ROLL_LEFT] && !lvl_w[ROLL_RIGHT]) roll_w = RATE_NEG;
  end

  state_e state_q, state_d;
  logic   latch_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (request_input) state_d = LATCH;
      LATCH:   state_d = READY;
      READY:   if (!request_input) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    input_ready = 1'b0;
    latch_en    = 1'b0;
    case (state_q)
      LATCH:   latch_en = 1'b1;
      READY:   input_ready = 1'b1;
      default: ;
    endcase
  end

  logic signed [INPUT_WIDTH-1:0] pitch_q, roll_q;
  logic [TW-1:0]                 thr_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pitch_q   <= '0;
      roll_q    <= '0;
      thr_out_q <= THR_INIT;
    end else if (latch_en) begin
      pitch_q   <= pitch_w;
      roll_q    <= roll_w;
      thr_out_q <= thr_q;
    end
  end

  assign pitch_change = pitch_q;
  assign roll_change  = roll_q;
  assign throttle     = thr_out_q;

endmodule
`default_nettype wire
